// File: rtl/vdp_cpu_bridge_if.sv
// rtl/vdp_cpu_bridge_if.sv - CPU bus / VDP port bundle for the VDP CPU bridge
// slave is the bridge side; master is the CPU bus plus VDP read-data source.
interface vdp_cpu_bridge_if;
    logic       sel;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_doe;
    logic       wait_n;
    logic       wr_tick;
    logic       rd_tick;
    logic       mode;
    logic [7:0] din;
    logic [7:0] dout;

    modport slave (
        input  sel, iorq_n, rd_n, wr_n, a0, cpu_din, dout,
        output cpu_dout, cpu_doe, wait_n, wr_tick, rd_tick, mode, din
    );

    modport master (
        output sel, iorq_n, rd_n, wr_n, a0, cpu_din, dout,
        input  cpu_dout, cpu_doe, wait_n, wr_tick, rd_tick, mode, din
    );
endinterface

// File: rtl/vdp_cpu_bridge.sv
// rtl/vdp_cpu_bridge.sv - async Z8S180 I/O strobes to pxclk-domain VDP ticks
// One tick per CPU strobe; reads are stretched with wait_n until data is latched.
module vdp_cpu_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input logic             clk,
    input logic             reset_n,
    vdp_cpu_bridge_if.slave bus
);
    localparam int CW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDHOLD,
        S_RELEASE
    } state_t;

    logic                   act_wr;
    logic                   act_rd;
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] rd_sync_q;
    logic [CW-1:0]          wr_cnt_q;
    logic [CW-1:0]          wr_cnt_d;
    logic [CW-1:0]          rd_cnt_q;
    logic [CW-1:0]          rd_cnt_d;
    logic                   wr_on;
    logic                   rd_on;
    logic                   wr_qual;
    logic                   rd_qual;
    state_t                 state_q;
    logic                   wr_tick_q;
    logic                   rd_tick_q;
    logic                   mode_q;
    logic                   rd_done_q;
    logic                   cpu_doe_q;
    logic                   block_q;
    logic [7:0]             din_q;
    logic [7:0]             cpu_dout_q;

    assign act_wr = bus.sel & ~bus.iorq_n & ~bus.wr_n;
    assign act_rd = bus.sel & ~bus.iorq_n & ~bus.rd_n;

    assign wr_on   = wr_sync_q[SYNC_STAGES-1];
    assign rd_on   = rd_sync_q[SYNC_STAGES-1];
    assign wr_qual = (wr_cnt_q == CW'(FILTER));
    assign rd_qual = (rd_cnt_q == CW'(FILTER));

    // Saturating glitch filters: any synced-inactive cycle restarts qualification.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (!wr_on)
            wr_cnt_d = '0;
        else if (!wr_qual)
            wr_cnt_d = wr_cnt_q + CW'(1);
        if (!rd_on)
            rd_cnt_d = '0;
        else if (!rd_qual)
            rd_cnt_d = rd_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sync_q <= '0;
            rd_sync_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], act_wr};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], act_rd};
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_tick_q  <= 1'b0;
            rd_tick_q  <= 1'b0;
            mode_q     <= 1'b0;
            din_q      <= 8'h00;
            cpu_dout_q <= 8'h00;
            cpu_doe_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            wr_tick_q <= 1'b0;
            rd_tick_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Simultaneous read and write is a bus fault: ignore until both drop.
                    if (block_q) begin
                        if (!wr_on && !rd_on)
                            block_q <= 1'b0;
                    end else if (wr_qual && rd_qual) begin
                        block_q <= 1'b1;
                    end else if (wr_qual) begin
                        state_q   <= S_WR;
                        wr_tick_q <= 1'b1;
                        mode_q    <= bus.a0;
                        din_q     <= bus.cpu_din;
                    end else if (rd_qual) begin
                        state_q   <= S_RD;
                        rd_tick_q <= 1'b1;
                        mode_q    <= bus.a0;
                    end
                end
                S_WR: begin
                    state_q <= S_RELEASE;
                end
                S_RD: begin
                    cpu_dout_q <= bus.dout;
                    rd_done_q  <= 1'b1;
                    cpu_doe_q  <= rd_on;
                    state_q    <= S_RDHOLD;
                end
                S_RDHOLD: begin
                    if (!rd_on) begin
                        state_q   <= S_IDLE;
                        rd_done_q <= 1'b0;
                        cpu_doe_q <= 1'b0;
                    end else begin
                        cpu_doe_q <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!wr_on)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Wait asserts combinationally so the CPU is held before the synchronizer sees the strobe.
    assign bus.wait_n   = ~(act_rd & ~rd_done_q);
    assign bus.wr_tick  = wr_tick_q;
    assign bus.rd_tick  = rd_tick_q;
    assign bus.mode     = mode_q;
    assign bus.din      = din_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.cpu_doe  = cpu_doe_q;
endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// tb/tb_vdp_cpu_bridge.sv - scoreboard bench for vdp_cpu_bridge
module tb_vdp_cpu_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    vdp_cpu_bridge_if bus ();

    vdp_cpu_bridge #(.SYNC_STAGES(2), .FILTER(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit         is_wr;
        bit         mode;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         last_tick = -100;
    bit         rd_pend = 0;
    logic [7:0] rd_exp = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every tick and checks latency, kind, mode and data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rd_pend) begin
                    rd_pend = 0;
                    check_val("rd_cpu_dout", bus.cpu_dout, rd_exp);
                    check_val("rd_cpu_doe", bus.cpu_doe, 1);
                end
                if (bus.wr_tick || bus.rd_tick) begin
                    check_val("tick_spacing", (cyc - last_tick >= 2), 1);
                    last_tick = cyc;
                    if (bus.wr_tick) wr_cnt++;
                    else rd_cnt++;
                    if (sb.size() == 0) begin
                        check_val("unexpected_tick", bus.wr_tick ? 1 : 2, 0);
                    end else begin
                        e = sb.pop_front();
                        check_val("tick_kind", bus.wr_tick, e.is_wr);
                        check_val("tick_both", bus.wr_tick & bus.rd_tick, 0);
                        check_val("tick_mode", bus.mode, e.mode);
                        check_val("tick_latency", cyc, e.cyc);
                        if (e.is_wr) begin
                            check_val("wr_din", bus.din, e.data);
                        end else begin
                            rd_pend = 1;
                            rd_exp  = e.data;
                        end
                    end
                end
            end
        end
    end

    task automatic do_write(input bit a0, input logic [7:0] d, input int hold, input int idle);
        exp_t e;
        e.is_wr = 1; e.mode = a0; e.data = d; e.cyc = cyc + 5;
        sb.push_back(e);
        bus.a0 = a0; bus.cpu_din = d;
        bus.sel = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
        #1 check_val("wr_wait_start", bus.wait_n, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("wr_wait_n", bus.wait_n, 1);
        end
        bus.wr_n = 1'b1; bus.iorq_n = 1'b1; bus.sel = 1'b0;
        bus.cpu_din = 8'hFF;
        repeat (idle) @(negedge clk);
    endtask

    task automatic do_read(input bit a0, input logic [7:0] d, input int hold, input int idle);
        exp_t e;
        int   t0;
        t0 = cyc;
        e.is_wr = 0; e.mode = a0; e.data = d; e.cyc = t0 + 5;
        sb.push_back(e);
        bus.dout = d; bus.a0 = a0;
        bus.sel = 1'b1; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        #1 check_val("rd_wait_assert", bus.wait_n, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (cyc <= t0 + 5) begin
                check_val("rd_wait_held", bus.wait_n, 0);
            end else begin
                check_val("rd_wait_release", bus.wait_n, 1);
                check_val("rd_doe_held", bus.cpu_doe, 1);
            end
        end
        bus.rd_n = 1'b1; bus.iorq_n = 1'b1; bus.sel = 1'b0;
        #1 check_val("rd_wait_idle", bus.wait_n, 1);
        repeat (idle) @(negedge clk);
        check_val("rd_doe_off", bus.cpu_doe, 0);
    endtask

    initial begin
        int   w0;
        int   r0;
        exp_t e;
        bus.sel = 1'b0; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        bus.a0 = 1'b0; bus.cpu_din = 8'h00; bus.dout = 8'h00;

        repeat (3) @(negedge clk);
        check_val("rst_wr_tick", bus.wr_tick, 0);
        check_val("rst_rd_tick", bus.rd_tick, 0);
        check_val("rst_mode", bus.mode, 0);
        check_val("rst_din", bus.din, 8'h00);
        check_val("rst_cpu_dout", bus.cpu_dout, 8'h00);
        check_val("rst_cpu_doe", bus.cpu_doe, 0);
        check_val("rst_wait_n", bus.wait_n, 1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        w0 = wr_cnt;
        do_write(1'b1, 8'h87, 12, 6);
        check_val("t1_wr_count", wr_cnt - w0, 1);

        r0 = rd_cnt;
        do_read(1'b0, 8'h5A, 15, 6);
        check_val("t2_rd_count", rd_cnt - r0, 1);

        w0 = wr_cnt;
        bus.sel = 1'b1; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.cpu_din = 8'h99;
        @(negedge clk);
        bus.sel = 1'b0; bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("t3_glitch_count", wr_cnt - w0, 0);

        w0 = wr_cnt;
        do_write(1'b0, 8'h11, 6, 3);
        do_write(1'b0, 8'h22, 6, 6);
        check_val("t4_wr_count", wr_cnt - w0, 2);

        r0 = rd_cnt;
        do_read(1'b1, 8'hC3, 100, 6);
        check_val("t5_rd_count", rd_cnt - r0, 1);

        r0 = rd_cnt;
        e.is_wr = 0; e.mode = 0; e.data = 8'h3C; e.cyc = cyc + 5;
        sb.push_back(e);
        bus.dout = 8'h3C; bus.a0 = 1'b0;
        bus.sel = 1'b1; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        repeat (8) @(negedge clk);
        check_val("t6_doe_before", bus.cpu_doe, 1);
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_doe", bus.cpu_doe, 0);
        check_val("t6_rst_rd_tick", bus.rd_tick, 0);
        check_val("t6_rst_wait_n", bus.wait_n, 0);
        @(negedge clk);
        reset_n = 1'b1;
        e.is_wr = 0; e.mode = 0; e.data = 8'h5D; e.cyc = cyc + 5;
        sb.push_back(e);
        bus.dout = 8'h5D;
        repeat (12) @(negedge clk);
        check_val("t6_rd_count", rd_cnt - r0, 2);
        check_val("t6_wait_after", bus.wait_n, 1);
        bus.sel = 1'b0; bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("t6_doe_off", bus.cpu_doe, 0);

        check_val("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
